// File: rtl/uart_tx_scheduler.sv
// uart_tx_scheduler: round-robin change/force scheduler feeding a UART byte FIFO.
// Optional periodic resend of every channel when TX_SCHED_REFRESH_EN is defined.
module uart_tx_scheduler #(
  parameter int         CHANNELS       = 4,
  parameter int         DEPTH          = 8,
  parameter logic [7:0] IDLE_BYTE      = 8'h00,
  parameter int         REFRESH_CYCLES = 153600
) (
  input  logic                                          clock,
  input  logic                                          reset,
  input  logic [8*CHANNELS-1:0]                         ch_data,
  input  logic [CHANNELS-1:0]                           ch_force,
  input  logic                                          tx_ready,
  output logic [7:0]                                    tx_bits,
  output logic [$clog2(DEPTH):0]                        fifo_count,
  output logic                                          stall,
  output logic [(CHANNELS > 1 ? $clog2(CHANNELS) : 1)-1:0] grant_ch,
  output logic                                          push
);

  localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int AW = $clog2(DEPTH);

  logic [7:0]          shadow [CHANNELS];
  logic [CHANNELS-1:0] force_pend;
  logic [CHANNELS-1:0] pending;
  logic [CHANNELS-1:0] refresh_set;
  logic [CHANNELS-1:0] grant_clr;
  logic [CW-1:0]       rr_ptr;
  logic [CW-1:0]       grant;
  logic [CW-1:0]       idx;
  logic                found;
  logic [7:0]          push_byte;

  logic [7:0]          mem [DEPTH];
  logic [AW-1:0]       wr_ptr;
  logic [AW-1:0]       rd_ptr;
  logic                full;
  logic                empty;
  logic                pop;

  assign full  = fifo_count == (AW+1)'(DEPTH);
  assign empty = fifo_count == '0;
  assign pop   = tx_ready & ~empty;

  // A channel is pending when its value differs from the last enqueued one or a resend is owed.
  always_comb begin
    pending = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      pending[i] = (ch_data[8*i +: 8] != shadow[i]) | force_pend[i];
    end
  end

  // Round-robin search for the first pending channel at or after rr_ptr.
  always_comb begin
    found = 1'b0;
    grant = '0;
    idx   = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      idx = CW'((int'(rr_ptr) + k) % CHANNELS);
      if (!found && pending[idx]) begin
        found = 1'b1;
        grant = idx;
      end
    end
  end

  // Select the granted channel's current byte.
  always_comb begin
    push_byte = 8'h00;
    for (int i = 0; i < CHANNELS; i++) begin
      if (grant == CW'(i)) push_byte = ch_data[8*i +: 8];
    end
  end

  assign push      = ~reset & found & ~full;
  assign grant_ch  = push ? grant : '0;
  assign stall     = full & (|pending);
  assign grant_clr = push ? (CHANNELS'(1) << grant) : '0;

`ifdef TX_SCHED_REFRESH_EN
  localparam int RW = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;

  logic [RW-1:0] refresh_cnt;
  logic          refresh_wrap;

  assign refresh_wrap = refresh_cnt == RW'(REFRESH_CYCLES - 1);
  assign refresh_set  = {CHANNELS{refresh_wrap}};

  // Free-running period counter; each wrap owes a resend on every channel.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)             refresh_cnt <= '0;
    else if (refresh_wrap) refresh_cnt <= '0;
    else                   refresh_cnt <= refresh_cnt + 1'b1;
  end
`else
  logic [31:0] unused_refresh;

  assign unused_refresh = 32'(REFRESH_CYCLES);
  assign refresh_set    = '0;
`endif

  // Shadow capture, force bookkeeping (set wins over grant clear) and rotation.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < CHANNELS; i++) shadow[i] <= 8'h00;
      force_pend <= '0;
      rr_ptr     <= '0;
    end else begin
      if (push) begin
        shadow[grant] <= push_byte;
        rr_ptr <= (grant == CW'(CHANNELS - 1)) ? '0 : grant + 1'b1;
      end
      force_pend <= (force_pend & ~grant_clr) | ch_force | refresh_set;
    end
  end

  // FIFO storage needs no reset; pointers define validity.
  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= push_byte;
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // Output byte only moves on a UART ready pulse; idle byte when nothing queued.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)         tx_bits <= IDLE_BYTE;
    else if (tx_ready) tx_bits <= empty ? IDLE_BYTE : mem[rd_ptr];
  end

endmodule

// File: doc/uart_tx_scheduler.md
# uart_tx_scheduler

Multi-channel byte scheduler that sits between the game-side logic (operation, target, game-state producers) and the UART transmitter's byte input. It generalises single-stream send logic: it watches CHANNELS independent 8-bit sources, enqueues a channel's byte whenever its value changes or a resend is forced, and arbitrates round-robin into a DEPTH-entry FIFO. It releases one byte per UART ready pulse, driving an idle byte when the queue is empty.

## Interface
- CHANNELS, 4: number of 8-bit sources, 1..8.
- DEPTH, 8: FIFO entries, power of two, ≥2.
- IDLE_BYTE, 8'h00: value presented when no queued byte.
- REFRESH_CYCLES, 153600: period of forced resend (only with TX_SCHED_REFRESH_EN).
- clock  in  1  UART-rate clock (16× baud); one clock, all logic on rising edge.
- reset  in  1  asynchronous, active-high reset.
- ch_data  in  8*CHANNELS  source bytes; channel i = bits [8i+7:8i].
- ch_force  in  CHANNELS  one-cycle pulse: enqueue channel i even if unchanged.
- tx_ready  in  1  UART pulse: current tx_bits has been transmitted.
- tx_bits  out  8  byte presented to UART io_dataIn_bits.
- fifo_count  out  $clog2(DEPTH)+1  queued entries.
- stall  out  1  FIFO full while any channel pending.
- grant_ch  out  $clog2(CHANNELS) (min 1)  channel enqueued this cycle (valid with push).
- push  out  1  an enqueue occurs this cycle.

## Operation
- Per channel: shadow register (last enqueued value) and force_pend flag. pending[i] = (ch_data[i] != shadow[i]) | force_pend[i].
- Arbiter: if pending != 0 and FIFO not full, grant first pending channel at or after rr_ptr (wrapping mod CHANNELS); push = 1; FIFO write ch_data[grant]; shadow[grant] <= ch_data[grant]; force_pend[grant] <= 0; rr_ptr <= (grant+1) mod CHANNELS.
- Coalescing: a channel changing several times while waiting produces one entry holding its value at grant time. A value that returns to shadow before grant produces no entry.
- ch_force[i] sets force_pend[i]; a force pulse on the grant cycle of channel i keeps force_pend[i] set (set wins).
- Drain: on tx_ready, if FIFO non-empty, tx_bits <= head and pop; else tx_bits <= IDLE_BYTE. tx_bits changes only on tx_ready or reset.
- FIFO: circular read/write pointers, wrap at DEPTH. Full = count==DEPTH, empty = count==0, both from registered count.
- Push and pop in the same cycle are permitted when not full; count unchanged. No push when full, even if a pop occurs that cycle. No bypass: with an empty FIFO, push+tx_ready in the same cycle yields IDLE_BYTE; the new byte goes out on the next ready.
- stall = full & (pending != 0), combinational.

## Timing
- Reset values: tx_bits=IDLE_BYTE, fifo_count=0, push=0, grant_ch=0, stall=0, shadows=0, force_pend=0, rr_ptr=0, pointers=0. Reset mid-operation discards queued bytes; it takes effect immediately (asynchronous).
- After reset, any nonzero ch_data is pending on the first cycle.
- Change-to-enqueue latency: 1 cycle when granted (ch_data changes before edge N, entry written at edge N). Worst case with all channels pending: CHANNELS cycles.
- Enqueue-to-output: byte appears on tx_bits at the first tx_ready edge at which it is FIFO head.
- push/grant_ch are combinational from registered state and current ch_data/pending.

## Configuration
- TX_SCHED_REFRESH_EN defined: a free-running counter 0..REFRESH_CYCLES-1. On wrap it sets force_pend for all channels, so every channel is re-sent at least once per period (game resync after a lost byte).
- Undefined: no counter, and REFRESH_CYCLES is ignored. Bytes are sent only on change or ch_force.

## Test plan
- Reset, ch_data={00,00,00,05}, tx_ready pulses every 20 cycles -> one push (grant_ch=0), tx_bits=05 at first ready, then 00 (IDLE_BYTE).
- Channels 0..3 change to 11,22,33,44 in the same cycle with rr_ptr=2 -> grant order 2,3,0,1; tx_bits sequence 33,44,11,22.
- Channel 1 changes A1→A2→A3 while FIFO full (DEPTH=8, no tx_ready) -> stall=1, fifo_count=8. After one tx_ready, a single A3 entry is enqueued and stall=0.
- ch_force[2] pulse with unchanged data 7E -> one 7E entry; a force on the grant cycle yields a second 7E entry.
- Simultaneous push and tx_ready at count=3 -> count stays 3. Empty FIFO with push+ready in the same cycle -> tx_bits=IDLE_BYTE, new byte out on the next ready. Reset asserted with 5 queued -> fifo_count=0 and tx_bits=00 immediately.
- With TX_SCHED_REFRESH_EN, REFRESH_CYCLES=100, static data {01,02,03,04} -> after each 100 cycles, four pushes 01..04. Without the macro -> no pushes after the initial four.
